// File: rtl/ysyx_23060136_ifu_arb_resp.sv
// Instruction-fetch response arbiter: turns one IFU fetch request into a
// single AXI-style AR/R memory read and hands back one doubleword response.
// Handles in-flight flushes (drop the response, still finish the bus read)
// and an R-phase timeout that answers with a NOP pair plus an error flag.
// Optional feature: define YSYX_23060136_IFU_RANGE_CHECK_EN to answer requests
// outside [ysyx_23060136_MBASE, ysyx_23060136_MEND) locally with an error.
`ifdef YSYX_23060136_IFU_RANGE_CHECK_EN
`ifndef ysyx_23060136_MBASE
`define ysyx_23060136_MBASE 32'h8000_0000
`endif
`ifndef ysyx_23060136_MEND
`define ysyx_23060136_MEND 32'h8800_0000
`endif
`endif

module ysyx_23060136_ifu_arb_resp #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 64,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] ARBITER_IFU_pc,
    input  logic              ARBITER_IFU_pc_valid,
    output logic              ARBITER_IFU_pc_ready,
    output logic [DATA_W-1:0] ARBITER_IFU_inst,
    output logic              ARBITER_IFU_inst_valid,
    input  logic              ARBITER_IFU_inst_ready,
    output logic              ARBITER_IFU_resp_err,
    input  logic              IFU_flush,
    output logic [ADDR_W-1:0] MEM_araddr,
    output logic              MEM_arvalid,
    input  logic              MEM_arready,
    input  logic [DATA_W-1:0] MEM_rdata,
    input  logic [1:0]        MEM_rresp,
    input  logic              MEM_rvalid,
    output logic              MEM_rready
);

    localparam logic [DATA_W-1:0] NOP_PAIR = DATA_W'(64'h00000013_00000013);
    localparam int CNT_W = (TIMEOUT_CYC < 1) ? 1 : $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC);

    typedef enum logic [1:0] {S_IDLE, S_AR, S_R, S_RESP} state_t;

    state_t            state_q;
    logic              pc_ready_q, arvalid_q, rready_q, inst_valid_q, err_q, drop_q;
    logic [ADDR_W-1:0] araddr_q;
    logic [DATA_W-1:0] inst_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_aligned;
    logic              timeout, drop_now, bypass;

    // Low address bits only matter to the optional range check.
    logic unused_pc_lo;
    assign unused_pc_lo = ^ARBITER_IFU_pc[2:0];

    assign addr_aligned = {ARBITER_IFU_pc[ADDR_W-1:3], 3'b000};
    // Last permitted wait cycle: this R cycle is the TIMEOUT_CYC-th one.
    assign timeout      = (32'(cnt_q) + 32'd1 >= 32'(TIMEOUT_CYC));
    // A flush arriving in the same cycle as the data still drops it.
    assign drop_now     = drop_q | IFU_flush;
    // Saturating wait counter; it must never wrap back into a live range.
    assign cnt_d        = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

`ifdef YSYX_23060136_IFU_RANGE_CHECK_EN
    assign bypass = !((ARBITER_IFU_pc >= ADDR_W'(`ysyx_23060136_MBASE)) &&
                      (ARBITER_IFU_pc <  ADDR_W'(`ysyx_23060136_MEND)));
`else
    assign bypass = 1'b0;
`endif

    // Fetch FSM with all outputs registered alongside the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            pc_ready_q   <= 1'b1;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            inst_valid_q <= 1'b0;
            err_q        <= 1'b0;
            drop_q       <= 1'b0;
            araddr_q     <= '0;
            inst_q       <= '0;
            cnt_q        <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (ARBITER_IFU_pc_valid) begin
                        araddr_q   <= addr_aligned;
                        pc_ready_q <= 1'b0;
                        if (bypass) begin
                            state_q      <= S_RESP;
                            inst_q       <= NOP_PAIR;
                            err_q        <= 1'b1;
                            inst_valid_q <= 1'b1;
                        end else begin
                            state_q   <= S_AR;
                            arvalid_q <= 1'b1;
                        end
                    end
                end
                S_AR: begin
                    if (IFU_flush) drop_q <= 1'b1;
                    if (MEM_arready) begin
                        state_q   <= S_R;
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        cnt_q     <= '0;
                    end
                end
                S_R: begin
                    if (IFU_flush) drop_q <= 1'b1;
                    if (!MEM_rvalid) cnt_q <= cnt_d;
                    if (MEM_rvalid || timeout) begin
                        rready_q <= 1'b0;
                        if (drop_now) begin
                            state_q    <= S_IDLE;
                            pc_ready_q <= 1'b1;
                            drop_q     <= 1'b0;
                        end else begin
                            state_q      <= S_RESP;
                            inst_valid_q <= 1'b1;
                            inst_q       <= MEM_rvalid ? MEM_rdata : NOP_PAIR;
                            err_q        <= MEM_rvalid ? (MEM_rresp != 2'b00) : 1'b1;
                        end
                    end
                end
                S_RESP: begin
                    if (IFU_flush || ARBITER_IFU_inst_ready) begin
                        state_q      <= S_IDLE;
                        inst_valid_q <= 1'b0;
                        pc_ready_q   <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= S_IDLE;
                    pc_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign ARBITER_IFU_pc_ready   = pc_ready_q;
    assign ARBITER_IFU_inst       = inst_q;
    assign ARBITER_IFU_inst_valid = inst_valid_q;
    assign ARBITER_IFU_resp_err   = err_q;
    assign MEM_araddr             = araddr_q;
    assign MEM_arvalid            = arvalid_q;
    assign MEM_rready             = rready_q;

endmodule
